// File: rtl/write_buffer.sv
// rtl/write_buffer.sv - store FIFO in front of mainmem; refill reads wait until every queued store has drained
module write_buffer #(
    parameter int DEPTH = 4,
    parameter int ADRW  = 27
) (
    input  logic            ph1,
    input  logic            reset,
    input  logic            wreq,
    input  logic [ADRW-1:0] wadr,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wbyteen,
    output logic            wready,
    input  logic            rreq,
    input  logic [ADRW-1:0] radr,
    output logic [31:0]     rdata,
    output logic            rack,
    output logic            wbempty,
    output logic [ADRW-1:0] memadr,
    output logic [31:0]     memwdata,
    output logic [3:0]      membyteen,
    output logic            memrwb,
    output logic            memen,
    input  logic [31:0]     memrdata,
    input  logic            memdone
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [ADRW-1:0] q_adr  [DEPTH];
    logic [31:0]     q_data [DEPTH];
    logic [3:0]      q_be   [DEPTH];

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [ADRW-1:0] rd_adr;
    logic            push;
    logic            pop;
    logic            rd_done;

    // No bypass on full: wready depends only on the registered count and the read request
    assign wready  = (count < FULL) && !rreq;
    assign push    = wreq && wready;
    assign pop     = (state == WRITE) && memdone;
    assign rd_done = (state == READ) && memdone;
    assign wbempty = (count == '0) && (state != WRITE);

    assign memrwb    = (state != WRITE);
    assign memadr    = (state == READ) ? rd_adr : q_adr[head];
    assign memwdata  = q_data[head];
    assign membyteen = (state == READ) ? 4'b1111 : q_be[head];

    // Queued stores always win over a waiting read so the read observes them
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = WRITE;
                end else if (rreq) begin
                    state_next = READ;
                end
            end
            WRITE: begin
                if (memdone) begin
                    state_next = IDLE;
                end
            end
            READ: begin
                if (memdone) begin
                    state_next = ACK;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            head   <= '0;
            tail   <= '0;
            memen  <= 1'b0;
            rack   <= 1'b0;
            rdata  <= '0;
            rd_adr <= '0;
        end else begin
            state <= state_next;
            memen <= (state_next == WRITE) || (state_next == READ);
            rack  <= rd_done;
            if (rd_done) begin
                rdata <= memrdata;
            end
            if ((state == IDLE) && (count == '0) && rreq) begin
                rd_adr <= radr;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage carries no reset; count alone decides which entries are live
    always_ff @(posedge ph1) begin
        if (push) begin
            q_adr[tail]  <= wadr;
            q_data[tail] <= wdata;
            q_be[tail]   <= wbyteen;
        end
    end
endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Memory-side stage directly downstream of the data cache; sits between the cache's store/refill path and mainmem.
- Queues word stores (address, data, byte enables) in a small FIFO and drains them to mainmem one at a time, so stores retire without waiting on memory.
- Arbitrates cache refill reads against queued writes. Reads are held until the buffer is empty, so a read always sees every earlier store.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of 2, minimum 2
ADRW, 27, word-address width (matches mainmem memadr)

Ports:
ph1  in  1  clock; all state updates on posedge ph1
reset  in  1  synchronous, active-high reset
wreq  in  1  store request from cache side
wadr  in  ADRW  store word address
wdata  in  32  store data
wbyteen  in  4  store byte enables; bit3 = [31:24]
wready  out  1  store accepted this cycle when wreq && wready
rreq  in  1  read request; held high until rack
radr  in  ADRW  read word address; stable while rreq high
rdata  out  32  read data; valid when rack = 1, held until the next read completes
rack  out  1  one-cycle read-complete pulse
wbempty  out  1  FIFO empty and no write in flight
memadr  out  ADRW  mainmem word address
memwdata  out  32  mainmem write data
membyteen  out  4  mainmem byte enables (4'b1111 on reads)
memrwb  out  1  1 = read, 0 = write
memen  out  1  mainmem transaction request
memrdata  in  32  mainmem read data; valid with memdone
memdone  in  1  mainmem completion, one-cycle pulse

Behaviour:
- Reset (synchronous) sets the following:
  - count = 0; head and tail pointers = 0; state = IDLE.
  - memen = 0, memrwb = 1, rack = 0, rdata = 0.
  - Result: wready = 1, wbempty = 1.
  - Reset mid-transaction discards all queued and in-flight writes; memen is 0 from the next cycle.
- wready = (count < DEPTH) && !rreq, decoded from registered state.
  - No bypass: a write is never accepted on a full FIFO, even when a pop happens in the same cycle.
  - wready is low while rreq is high, so pending writes drain and a read cannot be starved.
- Enqueue: on posedge with wreq && wready, the entry is written at tail, tail advances (wrapping modulo DEPTH), and count increments.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- FSM states: IDLE, WRITE, READ, ACK. memen is registered and is 1 exactly in WRITE and READ.
  - IDLE:
    - If count > 0, go to WRITE.
    - Else if rreq, go to READ and latch radr.
    - Else stay in IDLE.
    - Writes have priority over reads.
  - WRITE:
    - Drive memadr/memwdata/membyteen from the head entry, memrwb = 0.
    - Outputs stay stable until memdone.
    - On memdone: pop the head, return to IDLE.
  - READ:
    - Drive memadr = latched radr, membyteen = 4'b1111, memrwb = 1.
    - On memdone: capture rdata <= memrdata, set rack = 1, go to ACK.
  - ACK:
    - rack = 1 for exactly this one cycle.
    - No new read starts, even though rreq is still high; next state is IDLE.
    - The requester must drop rreq in the cycle after rack.
- memen drops for at least one cycle (the IDLE cycle) between consecutive transactions.
- memdone in IDLE or ACK is ignored.
- Memory timing:
  - Write latency to mainmem: the first entry reaches memen = 1 two edges after it is accepted.
  - Read with an empty buffer: memen = 1 one edge after rreq is seen; rack rises on the edge that samples memdone.
- wbempty = (count == 0) && (state != WRITE). A later sync/flush uses it.
- Byte enables pass through unchanged. Stores to the same address are not coalesced.

Test Plan:
- Reset, then wreq with wadr = 27'h10, wdata = 32'hDEADBEEF, wbyteen = 4'b0011; memdone 3 cycles after memen → memadr = 27'h10, memwdata = DEADBEEF, membyteen = 0011, memrwb = 0; wbempty = 1 after the pop.
- Four back-to-back stores with DEPTH = 4 and memdone held low → wready = 0 after the 4th; a 5th wreq is not accepted. Release memdone pulses → four writes in FIFO order, memen low one cycle between each.
- Two stores queued, then rreq with radr = 27'h20 → wready = 0. Both writes complete first, then the read: memrwb = 1, memadr = 27'h20. memdone with memrdata = 32'h12345678 → rdata = 12345678, rack high exactly one cycle, no second read started during ACK.
- Store at full count with a simultaneous memdone pop → store rejected (wready = 0 that cycle), count becomes DEPTH-1, next cycle's wreq accepted.
- Pointer wrap: 10 stores with prompt memdone → all 10 addresses appear on memadr in order; count never exceeds DEPTH.
- Reset asserted during WRITE with 3 entries queued → memen = 0 next cycle, wbempty = 1, subsequent memdone ignored, no further writes issued.
